// File: rtl/pong_pkg.sv
// Shared definitions for the pong ball engine: game states, coordinate,
// velocity and score types, and the screen/paddle geometry that the renderer
// and the edge logic also rely on.
package pong_pkg;

    localparam int SCR_W       = 640;
    localparam int SCR_H       = 480;
    localparam int BALL_SIZE   = 25;
    localparam int PAD_W       = 10;
    localparam int PAD_H       = 150;
    localparam int PAD_L_X     = 40;
    localparam int PAD_R_X     = 600;
    localparam int VEL_INIT    = 4;
    localparam int VEL_MAX     = 8;
    localparam int HOLD_FRAMES = 60;
    localparam int WIN_SCORE   = 9;

    // Ball top-left corner when centred on screen
    localparam int CENTRE_X = (SCR_W - BALL_SIZE) / 2;
    localparam int CENTRE_Y = (SCR_H - BALL_SIZE) / 2;

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    typedef logic signed [10:0] coord_t;
    typedef logic signed [4:0]  vel_t;
    typedef logic [3:0]         score_t;
    typedef logic [9:0]         pad_t;

    // Magnitude of a velocity component
    function automatic vel_t vel_abs(input vel_t v);
        return v[4] ? -v : v;
    endfunction

endpackage

// File: rtl/pong_collide.sv
// Combinational next-position/velocity calculator for one frame step:
// wall clamping, paddle reflection and miss (score) detection.
// Optional macro PONG_SPEEDUP_EN: each paddle reflection increases |vx| by
// one, capped at VEL_MAX; without it |vx| is left unchanged by reflections.
module pong_collide
    import pong_pkg::*;
(
    input  coord_t i_x,
    input  coord_t i_y,
    input  vel_t   i_vx,
    input  vel_t   i_vy,
    input  pad_t   i_pad_l_y,
    input  pad_t   i_pad_r_y,
    output coord_t o_nx,
    output coord_t o_ny,
    output vel_t   o_vx,
    output vel_t   o_vy,
    output logic   o_hit,
    output logic   o_score_l,
    output logic   o_score_r
);

    // All geometry compares are done in signed 12-bit arithmetic
    localparam logic signed [11:0] C_BOT      = 12'(SCR_H - BALL_SIZE);
    localparam logic signed [11:0] C_BALL_M1  = 12'(BALL_SIZE - 1);
    localparam logic signed [11:0] C_PADH_M1  = 12'(PAD_H - 1);
    localparam logic signed [11:0] C_PADL_IN  = 12'(PAD_L_X + PAD_W - 1);
    localparam logic signed [11:0] C_PADL_OUT = 12'(PAD_L_X + PAD_W);
    localparam logic signed [11:0] C_PADR_X   = 12'(PAD_R_X);
    localparam logic signed [11:0] C_PADR_OUT = 12'(PAD_R_X - BALL_SIZE);
    localparam logic signed [11:0] C_MISS_L   = 12'(-BALL_SIZE);
    localparam logic signed [11:0] C_MISS_R   = 12'(SCR_W);

    logic signed [11:0] w_x;
    logic signed [11:0] w_y;
    logic signed [11:0] w_nx0;
    logic signed [11:0] w_ny0;
    logic signed [11:0] w_nx;
    logic signed [11:0] w_ny;
    logic signed [11:0] w_pl;
    logic signed [11:0] w_pr;
    vel_t               w_vx_mag;
    vel_t               w_vy_mag;
    vel_t               w_vx_hit_mag;
    logic               w_ovl_l;
    logic               w_ovl_r;
    logic               w_hit_l;
    logic               w_hit_r;

    assign w_x   = {i_x[10], i_x};
    assign w_y   = {i_y[10], i_y};
    assign w_nx0 = w_x + {{7{i_vx[4]}}, i_vx};
    assign w_ny0 = w_y + {{7{i_vy[4]}}, i_vy};
    assign w_pl  = {2'b00, i_pad_l_y};
    assign w_pr  = {2'b00, i_pad_r_y};

    assign w_vx_mag = vel_abs(i_vx);
    assign w_vy_mag = vel_abs(i_vy);

`ifdef PONG_SPEEDUP_EN
    localparam vel_t C_VEL_MAX = 5'(VEL_MAX);
    assign w_vx_hit_mag = (w_vx_mag >= C_VEL_MAX) ? C_VEL_MAX : w_vx_mag + 5'sd1;
`else
    assign w_vx_hit_mag = w_vx_mag;
`endif

    // Vertical step with clamping against the top and bottom walls
    always_comb begin
        w_ny = w_ny0;
        o_vy = i_vy;
        if (w_ny0[11]) begin
            w_ny = '0;
            o_vy = w_vy_mag;
        end else if (w_ny0 > C_BOT) begin
            w_ny = C_BOT;
            o_vy = -w_vy_mag;
        end
    end

    // Paddle overlap uses the already-clamped vertical position
    assign w_ovl_l = (w_ny + C_BALL_M1 >= w_pl) && (w_ny <= w_pl + C_PADH_M1);
    assign w_ovl_r = (w_ny + C_BALL_M1 >= w_pr) && (w_ny <= w_pr + C_PADH_M1);

    // Only a ball crossing the paddle face this step reflects
    assign w_hit_l = i_vx[4] && (w_nx0 <= C_PADL_IN) && (w_x >= C_PADL_OUT) && w_ovl_l;
    assign w_hit_r = !i_vx[4] && (i_vx != '0) && (w_nx0 + C_BALL_M1 >= C_PADR_X)
                     && (w_x + C_BALL_M1 < C_PADR_X) && w_ovl_r;

    // Horizontal step: paddle reflection wins over a miss
    always_comb begin
        w_nx  = w_nx0;
        o_vx  = i_vx;
        o_hit = 1'b0;
        if (w_hit_l) begin
            w_nx  = C_PADL_OUT;
            o_vx  = w_vx_hit_mag;
            o_hit = 1'b1;
        end else if (w_hit_r) begin
            w_nx  = C_PADR_OUT;
            o_vx  = -w_vx_hit_mag;
            o_hit = 1'b1;
        end
    end

    assign o_score_r = (w_nx <= C_MISS_L);
    assign o_score_l = (w_nx >= C_MISS_R);
    assign o_nx      = w_nx[10:0];
    assign o_ny      = w_ny[10:0];

endmodule

// File: rtl/pong_ball_engine.sv
// Pong game-logic stage: advances the ball once per frame tick, reflects it
// off walls and paddles, detects misses and keeps score. Feeds the ball
// position to the pixel renderer. Optional macro PONG_SPEEDUP_EN enables
// paddle-hit speedup inside pong_collide.
//
// tick and serve are single-cycle strobes with no back-pressure: a strobe is
// acted on in the cycle it is high if the current state accepts it, and is
// otherwise dropped. Reset overrides both in every state.
module pong_ball_engine
    import pong_pkg::*;
(
    input  logic               pixel_clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               serve,
    input  logic [9:0]         paddle_L_y,
    input  logic [9:0]         paddle_R_y,
    output logic signed [10:0] ball_x,
    output logic signed [10:0] ball_y,
    output logic [3:0]         score_L,
    output logic [3:0]         score_R,
    output logic               hit,
    output logic               point,
    output logic               game_over,
    output logic [1:0]         state
);

    localparam coord_t     C_CX         = 11'(CENTRE_X);
    localparam coord_t     C_CY         = 11'(CENTRE_Y);
    localparam vel_t       C_VEL_INIT   = 5'(VEL_INIT);
    localparam vel_t       C_VEL_INIT_N = 5'(-VEL_INIT);
    localparam score_t     C_WIN        = 4'(WIN_SCORE);
    localparam logic [5:0] C_HOLD_LAST  = 6'(HOLD_FRAMES - 1);

    state_t     r_state;
    coord_t     r_x;
    coord_t     r_y;
    vel_t       r_vx;
    vel_t       r_vy;
    score_t     r_score_l;
    score_t     r_score_r;
    logic       r_hit;
    logic       r_point;
    logic       r_game_over;
    logic [5:0] r_hold_cnt;

    state_t     w_state_next;
    coord_t     w_x_next;
    coord_t     w_y_next;
    vel_t       w_vx_next;
    vel_t       w_vy_next;
    score_t     w_score_l_next;
    score_t     w_score_r_next;
    logic       w_hit_next;
    logic       w_point_next;
    logic [5:0] w_hold_next;
    score_t     w_sl_inc;
    score_t     w_sr_inc;

    coord_t     w_c_nx;
    coord_t     w_c_ny;
    vel_t       w_c_vx;
    vel_t       w_c_vy;
    logic       w_c_hit;
    logic       w_c_score_l;
    logic       w_c_score_r;

    // Paddle inputs only matter on tick cycles, where the result is used
    pong_collide u_collide (
        .i_x       (r_x),
        .i_y       (r_y),
        .i_vx      (r_vx),
        .i_vy      (r_vy),
        .i_pad_l_y (paddle_L_y),
        .i_pad_r_y (paddle_R_y),
        .o_nx      (w_c_nx),
        .o_ny      (w_c_ny),
        .o_vx      (w_c_vx),
        .o_vy      (w_c_vy),
        .o_hit     (w_c_hit),
        .o_score_l (w_c_score_l),
        .o_score_r (w_c_score_r)
    );

    assign w_sl_inc = (r_score_l >= C_WIN) ? C_WIN : r_score_l + 4'd1;
    assign w_sr_inc = (r_score_r >= C_WIN) ? C_WIN : r_score_r + 4'd1;

    // Next-state and next-register values; everything holds unless acted on
    always_comb begin
        w_state_next   = r_state;
        w_x_next       = r_x;
        w_y_next       = r_y;
        w_vx_next      = r_vx;
        w_vy_next      = r_vy;
        w_score_l_next = r_score_l;
        w_score_r_next = r_score_r;
        w_hit_next     = 1'b0;
        w_point_next   = 1'b0;
        w_hold_next    = r_hold_cnt;
        case (r_state)
            ST_SERVE: begin
                // Serve launches with the stored direction at serve speed
                if (serve) begin
                    w_state_next = ST_PLAY;
                    w_vx_next    = r_vx[4] ? C_VEL_INIT_N : C_VEL_INIT;
                end
            end
            ST_PLAY: begin
                if (tick) begin
                    w_x_next   = w_c_nx;
                    w_y_next   = w_c_ny;
                    w_vx_next  = w_c_vx;
                    w_vy_next  = w_c_vy;
                    w_hit_next = w_c_hit;
                    if (w_c_score_l || w_c_score_r) begin
                        w_point_next = 1'b1;
                        w_x_next     = C_CX;
                        w_y_next     = C_CY;
                        w_vy_next    = C_VEL_INIT;
                        w_hold_next  = '0;
                        w_state_next = ST_HOLD;
                        if (w_c_score_l) begin
                            // Right player lost: next serve heads right
                            w_score_l_next = w_sl_inc;
                            w_vx_next      = C_VEL_INIT;
                            if (w_sl_inc == C_WIN) w_state_next = ST_OVER;
                        end else begin
                            // Left player lost: next serve heads left
                            w_score_r_next = w_sr_inc;
                            w_vx_next      = C_VEL_INIT_N;
                            if (w_sr_inc == C_WIN) w_state_next = ST_OVER;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    if (r_hold_cnt == C_HOLD_LAST) begin
                        w_hold_next  = '0;
                        w_state_next = ST_SERVE;
                    end else begin
                        w_hold_next = r_hold_cnt + 6'd1;
                    end
                end
            end
            ST_OVER: begin
                // Terminal until reset
            end
            default: begin
                w_state_next = ST_SERVE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            r_state     <= ST_SERVE;
            r_x         <= C_CX;
            r_y         <= C_CY;
            r_vx        <= C_VEL_INIT;
            r_vy        <= C_VEL_INIT;
            r_score_l   <= '0;
            r_score_r   <= '0;
            r_hit       <= 1'b0;
            r_point     <= 1'b0;
            r_game_over <= 1'b0;
            r_hold_cnt  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_x         <= w_x_next;
            r_y         <= w_y_next;
            r_vx        <= w_vx_next;
            r_vy        <= w_vy_next;
            r_score_l   <= w_score_l_next;
            r_score_r   <= w_score_r_next;
            r_hit       <= w_hit_next;
            r_point     <= w_point_next;
            r_game_over <= (w_state_next == ST_OVER);
            r_hold_cnt  <= w_hold_next;
        end
    end

    assign ball_x    = r_x;
    assign ball_y    = r_y;
    assign score_L   = r_score_l;
    assign score_R   = r_score_r;
    assign hit       = r_hit;
    assign point     = r_point;
    assign game_over = r_game_over;
    assign state     = r_state;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed testbench for pong_ball_engine. Inputs change on the falling edge,
// outputs are sampled on the falling edge after the rising edge that acted.
module tb_pong_ball_engine;

    logic               pixel_clk = 1'b0;
    logic               reset = 1'b1;
    logic               tick = 1'b0;
    logic               serve = 1'b0;
    logic [9:0]         paddle_L_y = '0;
    logic [9:0]         paddle_R_y = '0;
    logic signed [10:0] ball_x;
    logic signed [10:0] ball_y;
    logic [3:0]         score_L;
    logic [3:0]         score_R;
    logic               hit;
    logic               point;
    logic               game_over;
    logic [1:0]         state;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    pong_ball_engine dut (
        .pixel_clk  (pixel_clk),
        .reset      (reset),
        .tick       (tick),
        .serve      (serve),
        .paddle_L_y (paddle_L_y),
        .paddle_R_y (paddle_R_y),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .score_L    (score_L),
        .score_R    (score_R),
        .hit        (hit),
        .point      (point),
        .game_over  (game_over),
        .state      (state)
    );

    // Clock
    always #5 pixel_clk = ~pixel_clk;

    // Driver tasks
    task automatic do_reset();
        @(negedge pixel_clk);
        reset = 1'b1;
        tick  = 1'b0;
        serve = 1'b0;
        @(negedge pixel_clk);
        @(negedge pixel_clk);
        reset = 1'b0;
    endtask

    task automatic do_tick();
        @(negedge pixel_clk);
        tick = 1'b1;
        @(negedge pixel_clk);
        tick = 1'b0;
    endtask

    task automatic do_serve();
        @(negedge pixel_clk);
        serve = 1'b1;
        @(negedge pixel_clk);
        serve = 1'b0;
    endtask

    task automatic do_serve_tick();
        @(negedge pixel_clk);
        serve = 1'b1;
        tick  = 1'b1;
        @(negedge pixel_clk);
        serve = 1'b0;
        tick  = 1'b0;
    endtask

    task automatic test_reset();
        int pulses;
        pulses = 0;
        do_reset();
        for (int t = 0; t < 10; t++) begin
            do_tick();
            if (hit === 1'b1 || point === 1'b1) pulses++;
        end
        chk_cnt++;
        if ({ball_x, ball_y} !== {11'sd307, 11'sd227})
            $display("FAIL reset_ball: got (%0d,%0d) want (307,227)", ball_x, ball_y);
        else pass_cnt++;
        chk_cnt++;
        if ({score_L, score_R, state, game_over} !== {4'd0, 4'd0, 2'd0, 1'b0})
            $display("FAIL reset_status: got L=%0d R=%0d st=%0d go=%0b want 0 0 0 0",
                     score_L, score_R, state, game_over);
        else pass_cnt++;
        chk_cnt++;
        if (pulses !== 0)
            $display("FAIL reset_pulses: got %0d hit/point pulses want 0", pulses);
        else pass_cnt++;
    endtask

    task automatic test_serve();
        do_reset();
        do_serve();
        chk_cnt++;
        if ({state, ball_x, ball_y} !== {2'd1, 11'sd307, 11'sd227})
            $display("FAIL serve_enter: got st=%0d (%0d,%0d) want 1 (307,227)", state, ball_x, ball_y);
        else pass_cnt++;
        do_tick();
        chk_cnt++;
        if ({ball_x, ball_y} !== {11'sd311, 11'sd231})
            $display("FAIL serve_first_step: got (%0d,%0d) want (311,231)", ball_x, ball_y);
        else pass_cnt++;
        repeat (3) @(negedge pixel_clk);
        chk_cnt++;
        if ({ball_x, ball_y} !== {11'sd311, 11'sd231})
            $display("FAIL idle_hold: got (%0d,%0d) want (311,231)", ball_x, ball_y);
        else pass_cnt++;
        do_reset();
        do_serve_tick();
        chk_cnt++;
        if ({state, ball_x, ball_y} !== {2'd1, 11'sd307, 11'sd227})
            $display("FAIL serve_with_tick: got st=%0d (%0d,%0d) want 1 (307,227)", state, ball_x, ball_y);
        else pass_cnt++;
        do_tick();
        chk_cnt++;
        if ({ball_x, ball_y} !== {11'sd311, 11'sd231})
            $display("FAIL serve_with_tick_step: got (%0d,%0d) want (311,231)", ball_x, ball_y);
        else pass_cnt++;
    endtask

    task automatic test_paddle_walls();
        int hits;
        int last_t;
        int exp_x69;
`ifdef PONG_SPEEDUP_EN
        exp_x69 = 570;
        last_t  = 69;
`else
        exp_x69 = 571;
        last_t  = 201;
`endif
        hits = 0;
        do_reset();
        paddle_R_y = 10'd300;
        paddle_L_y = 10'd100;
        do_serve();
        for (int t = 1; t <= last_t; t++) begin
            do_tick();
            if (hit === 1'b1) hits++;
            if (t == 58) begin
                chk_cnt++;
                if ({ball_x, ball_y} !== {11'sd539, 11'sd455})
                    $display("FAIL bottom_clamp: got (%0d,%0d) want (539,455)", ball_x, ball_y);
                else pass_cnt++;
            end
            if (t == 59) begin
                chk_cnt++;
                if (ball_y !== 11'sd451)
                    $display("FAIL bottom_reflect: got y=%0d want 451", ball_y);
                else pass_cnt++;
            end
            if (t == 68) begin
                chk_cnt++;
                if ({ball_x, ball_y, hit} !== {11'sd575, 11'sd415, 1'b1})
                    $display("FAIL right_hit: got (%0d,%0d) hit=%0b want (575,415) hit=1", ball_x, ball_y, hit);
                else pass_cnt++;
            end
            if (t == 69) begin
                chk_cnt++;
                if ({hit, ball_x} !== {1'b0, 11'(exp_x69)})
                    $display("FAIL right_rebound: got x=%0d hit=%0b want x=%0d hit=0", ball_x, hit, exp_x69);
                else pass_cnt++;
            end
            if (t == 172) begin
                chk_cnt++;
                if ({ball_x, ball_y} !== {11'sd159, 11'sd0})
                    $display("FAIL top_clamp: got (%0d,%0d) want (159,0)", ball_x, ball_y);
                else pass_cnt++;
            end
            if (t == 173) begin
                chk_cnt++;
                if (ball_y !== 11'sd4)
                    $display("FAIL top_reflect: got y=%0d want 4", ball_y);
                else pass_cnt++;
            end
            if (t == 200) begin
                chk_cnt++;
                if ({ball_x, ball_y, hit} !== {11'sd50, 11'sd112, 1'b1})
                    $display("FAIL left_hit: got (%0d,%0d) hit=%0b want (50,112) hit=1", ball_x, ball_y, hit);
                else pass_cnt++;
            end
            if (t == 201) begin
                chk_cnt++;
                if (ball_x !== 11'sd54)
                    $display("FAIL left_rebound: got x=%0d want 54", ball_x);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if (hits !== ((last_t > 199) ? 2 : 1))
            $display("FAIL hit_count: got %0d want %0d", hits, (last_t > 199) ? 2 : 1);
        else pass_cnt++;
    endtask

    task automatic test_score_l();
        int hits;
        hits = 0;
        do_reset();
        paddle_R_y = 10'd0;
        paddle_L_y = 10'd100;
        do_serve();
        for (int t = 1; t <= 84; t++) begin
            do_tick();
            if (hit === 1'b1) hits++;
            if (t == 83) begin
                chk_cnt++;
                if ({ball_x, ball_y, score_L, state} !== {11'sd639, 11'sd355, 4'd0, 2'd1})
                    $display("FAIL pre_score_l: got (%0d,%0d) L=%0d st=%0d want (639,355) 0 1",
                             ball_x, ball_y, score_L, state);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if ({score_L, score_R, point, state, ball_x, ball_y} !==
            {4'd1, 4'd0, 1'b1, 2'd2, 11'sd307, 11'sd227})
            $display("FAIL score_l: got L=%0d R=%0d pt=%0b st=%0d (%0d,%0d) want 1 0 1 2 (307,227)",
                     score_L, score_R, point, state, ball_x, ball_y);
        else pass_cnt++;
        chk_cnt++;
        if (hits !== 0)
            $display("FAIL miss_no_hit: got %0d hits want 0", hits);
        else pass_cnt++;
        @(negedge pixel_clk);
        chk_cnt++;
        if (point !== 1'b0)
            $display("FAIL point_pulse_width: got point=%0b want 0", point);
        else pass_cnt++;
        repeat (59) do_tick();
        chk_cnt++;
        if ({state, ball_x, ball_y} !== {2'd2, 11'sd307, 11'sd227})
            $display("FAIL hold_59: got st=%0d (%0d,%0d) want 2 (307,227)", state, ball_x, ball_y);
        else pass_cnt++;
        do_tick();
        chk_cnt++;
        if (state !== 2'd0)
            $display("FAIL hold_60: got st=%0d want 0", state);
        else pass_cnt++;
        do_serve();
        do_tick();
        chk_cnt++;
        if ({ball_x, ball_y} !== {11'sd311, 11'sd231})
            $display("FAIL reserve_right: got (%0d,%0d) want (311,231)", ball_x, ball_y);
        else pass_cnt++;
    endtask

    task automatic test_score_r();
        do_reset();
        paddle_R_y = 10'd300;
        paddle_L_y = 10'd400;
        do_serve();
        for (int t = 1; t <= 218; t++) begin
            do_tick();
            if (t == 217) begin
                chk_cnt++;
                if ({ball_x, score_R, state} !== {-11'sd21, 4'd0, 2'd1})
                    $display("FAIL pre_score_r: got x=%0d R=%0d st=%0d want -21 0 1", ball_x, score_R, state);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if ({score_R, score_L, point, state, ball_x, ball_y} !==
            {4'd1, 4'd0, 1'b1, 2'd2, 11'sd307, 11'sd227})
            $display("FAIL score_r: got R=%0d L=%0d pt=%0b st=%0d (%0d,%0d) want 1 0 1 2 (307,227)",
                     score_R, score_L, point, state, ball_x, ball_y);
        else pass_cnt++;
        repeat (60) do_tick();
        do_serve();
        do_tick();
        chk_cnt++;
        if ({ball_x, ball_y} !== {11'sd303, 11'sd231})
            $display("FAIL reserve_left: got (%0d,%0d) want (303,231)", ball_x, ball_y);
        else pass_cnt++;
    endtask

    task automatic test_game_over();
        int n;
        do_reset();
        paddle_R_y = 10'd0;
        paddle_L_y = 10'd100;
        for (int r = 1; r <= 9; r++) begin
            do_serve();
            n = 0;
            while (point !== 1'b1 && n < 200) begin
                do_tick();
                n++;
            end
            chk_cnt++;
            if (n !== 84) begin
                $display("FAIL round_%0d_len: got %0d ticks to point want 84", r, n);
                break;
            end else pass_cnt++;
            if (r < 9) repeat (60) do_tick();
        end
        chk_cnt++;
        if ({score_L, score_R, game_over, state} !== {4'd9, 4'd0, 1'b1, 2'd3})
            $display("FAIL game_over: got L=%0d R=%0d go=%0b st=%0d want 9 0 1 3",
                     score_L, score_R, game_over, state);
        else pass_cnt++;
        do_serve_tick();
        do_tick();
        do_serve();
        chk_cnt++;
        if ({state, score_L, ball_x, ball_y, game_over} !== {2'd3, 4'd9, 11'sd307, 11'sd227, 1'b1})
            $display("FAIL over_sticky: got st=%0d L=%0d (%0d,%0d) go=%0b want 3 9 (307,227) 1",
                     state, score_L, ball_x, ball_y, game_over);
        else pass_cnt++;
        do_reset();
        chk_cnt++;
        if ({state, score_L, score_R, game_over} !== {2'd0, 4'd0, 4'd0, 1'b0})
            $display("FAIL over_reset: got st=%0d L=%0d R=%0d go=%0b want 0 0 0 0",
                     state, score_L, score_R, game_over);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_serve();
        test_paddle_walls();
        test_score_l();
`ifndef PONG_SPEEDUP_EN
        test_score_r();
`endif
        test_game_over();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
